// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_ASR = 4'd10,
        OP_MUL = 4'd11
    } op_t;

    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_P = 2;
    localparam int F_N = 3;
    localparam int F_V = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Multi-cycle engine: one shift step or one shift-add MUL step per cycle.
// o_lo/o_hi/o_c are the values after the current step; o_last marks the final step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_c
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] B_MAX = WIDTH'(WIDTH);

    op_t             r_op;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_mcand;
    logic            r_c;
    logic [WIDTH:0]  w_sum;
    logic [CW-1:0]   w_cnt0;

    // Shift amounts of WIDTH or more saturate at WIDTH steps.
    always_comb begin
        if (op_t'(i_op) == OP_MUL || i_b >= B_MAX)
            w_cnt0 = CW'(WIDTH);
        else
            w_cnt0 = i_b[CW-1:0];
    end

    always_comb begin
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        o_lo  = r_lo;
        o_hi  = r_hi;
        o_c   = r_c;
        case (r_op)
            OP_SHL: begin
                o_lo = {r_lo[WIDTH-2:0], 1'b0};
                o_c  = r_lo[WIDTH-1];
            end
            OP_SHR: begin
                o_lo = {1'b0, r_lo[WIDTH-1:1]};
                o_c  = r_lo[0];
            end
            OP_ASR: begin
                o_lo = {r_lo[WIDTH-1], r_lo[WIDTH-1:1]};
                o_c  = r_lo[0];
            end
            OP_MUL: begin
                // {hi,lo} shifts right; the multiplier drains out of lo as product bits fill in.
                o_hi = w_sum[WIDTH:1];
                o_lo = {w_sum[0], r_lo[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    assign o_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_ADD;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_mcand <= '0;
            r_c     <= 1'b0;
        end else if (i_start) begin
            r_op    <= op_t'(i_op);
            r_cnt   <= w_cnt0;
            r_lo    <= i_a;
            r_hi    <= '0;
            r_mcand <= i_b;
            r_c     <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_lo  <= o_lo;
            r_hi  <= o_hi;
            r_c   <= o_c;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU with valid/ready handshake and a persistent flag register.
// Single-cycle ops resolve at acceptance; shifts and MUL are handed to alu_iter_unit.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] dh,
    output logic [7:0]       fo
);

    state_t           r_state, w_nxt;
    op_t              r_op, w_op;
    logic [WIDTH-1:0] r_d, r_dh;
    logic [7:0]       r_fo;
    logic             r_vld;

    logic [WIDTH:0]   w_sum, w_cin;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v, w_upd, w_iter;
    logic             w_acc, w_start, w_load, w_fin;
    logic             w_ulast, w_uc;
    logic [WIDTH-1:0] w_ulo, w_uhi;

    assign w_op = op_t'(op);

    function automatic logic [7:0] flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [7:0] f;
        f      = '0;
        f[F_C] = c;
        f[F_Z] = (r == '0);
        f[F_N] = r[WIDTH-1];
        f[F_P] = (r != '0) && !r[WIDTH-1];
        f[F_V] = v;
        return f;
    endfunction

    always_comb begin
        w_cin    = '0;
        w_cin[0] = r_fo[F_C] && (w_op == OP_ADC || w_op == OP_SBC);
        w_sum    = '0;
        w_res    = '0;
        w_c      = r_fo[F_C];
        w_v      = 1'b0;
        w_upd    = 1'b1;
        w_iter   = 1'b0;
        case (w_op)
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, a} + {1'b0, b} + w_cin;
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the wrapped difference is the borrow.
                w_sum = {1'b0, a} - {1'b0, b} - w_cin;
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL, OP_SHR, OP_ASR: begin
                w_res  = a;
                w_iter = (b != '0);
            end
            OP_MUL: w_iter = 1'b1;
            default: w_upd = 1'b0;
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_unit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_last  (w_ulast),
        .o_lo    (w_ulo),
        .o_hi    (w_uhi),
        .o_c     (w_uc)
    );

    always_comb begin
        w_nxt    = r_state;
        w_start  = 1'b0;
        w_load   = 1'b0;
        w_fin    = 1'b0;
        in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
        w_acc    = in_valid && in_ready;
        if (w_acc) begin
            if (w_iter) begin
                w_nxt   = EXEC;
                w_start = 1'b1;
            end else begin
                w_nxt  = DONE;
                w_load = 1'b1;
            end
        end else begin
            case (r_state)
                EXEC: if (w_ulast) begin
                    w_nxt = DONE;
                    w_fin = 1'b1;
                end
                DONE: if (out_ready) w_nxt = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_ADD;
            r_d     <= '0;
            r_dh    <= '0;
            r_fo    <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_vld   <= (w_nxt == DONE);
            if (w_start) r_op <= w_op;
            if (w_load) begin
                r_d  <= w_res;
                r_dh <= '0;
                if (w_upd) r_fo <= flags(w_res, w_c, w_v);
            end
            if (w_fin) begin
                r_d <= w_ulo;
                if (r_op == OP_MUL) begin
                    r_dh <= w_uhi;
                    r_fo <= flags(w_ulo, 1'b0, w_uhi != '0);
                end else begin
                    r_dh <= '0;
                    r_fo <= flags(w_ulo, w_uc, 1'b0);
                end
            end
        end
    end

    assign d         = r_d;
    assign dh        = r_dh;
    assign fo        = r_fo;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: an integer-arithmetic reference model feeds a scoreboard
// checked every cycle, plus literal expectations for the headline vectors.
module tb_alu_iter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, d, dh;
    logic [3:0]   op;
    logic [7:0]   fo;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        int d;
        int dh;
        int fo;
        int lat;
        int acc;
        bit seen;
    } exp_t;

    exp_t q[$];
    int   m_fo = 0;

    alu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .dh        (dh),
        .fo        (fo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer arithmetic on the op's definition.
    function automatic exp_t model(input int o, input int ua, input int ub, input int fin);
        exp_t e;
        int M, H, sa, sb, r, sr, hi, c, v, n, cin, z, ng, p;
        bit upd;
        M = 1 << W;  H = M / 2;
        sa = (ua >= H) ? ua - M : ua;
        sb = (ub >= H) ? ub - M : ub;
        cin = fin & 1;  c = cin;  v = 0;  hi = 0;  r = 0;  upd = 1;
        n = (ub < W) ? ub : W;
        e.lat = 1;
        case (o)
            0, 1: begin
                r  = ua + ub + ((o == 1) ? cin : 0);
                sr = sa + sb + ((o == 1) ? cin : 0);
                c  = (r >= M) ? 1 : 0;
                v  = (sr >= H || sr < -H) ? 1 : 0;
                r  = r % M;
            end
            2, 3: begin
                r  = ua - ub - ((o == 3) ? cin : 0);
                sr = sa - sb - ((o == 3) ? cin : 0);
                c  = (r < 0) ? 1 : 0;
                v  = (sr >= H || sr < -H) ? 1 : 0;
                r  = (r + M) % M;
            end
            4: r = ua & ub;
            5: r = ua | ub;
            6: r = ua ^ ub;
            7: r = (~ua) & (M - 1);
            8: begin
                r = (ua << n) % M;
                if (n > 0) c = (ua >> (W - n)) & 1;
                e.lat = 1 + n;
            end
            9, 10: begin
                r = (o == 9) ? (ua >> n) : ((sa >>> n) & (M - 1));
                if (n > 0) c = (ua >> (n - 1)) & 1;
                e.lat = 1 + n;
            end
            11: begin
                r  = (ua * ub) % M;
                hi = (ua * ub) / M;
                c  = 0;
                v  = (hi != 0) ? 1 : 0;
                e.lat = 1 + W;
            end
            default: upd = 0;
        endcase
        z  = (r == 0) ? 1 : 0;
        ng = (r >= H) ? 1 : 0;
        p  = (!z && !ng) ? 1 : 0;
        e.d    = r;
        e.dh   = hi;
        e.fo   = upd ? ((v << 4) | (ng << 3) | (p << 2) | (z << 1) | c) : fin;
        e.acc  = 0;
        e.seen = 0;
        return e;
    endfunction

    // Scoreboard: latency is counted so that a result visible right after the accept edge is 1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() == 0) begin
                chk("valid_idle", int'(out_valid), 0);
                chk("in_ready_idle", int'(in_ready), 1);
            end else begin
                chk("in_ready", int'(in_ready), (out_valid && out_ready) ? 1 : 0);
                if (out_valid) begin
                    if (!q[0].seen) begin
                        chk("latency", cyc - q[0].acc + 1, q[0].lat);
                        q[0].seen = 1;
                    end
                    chk("d", int'(d), q[0].d);
                    chk("dh", int'(dh), q[0].dh);
                    chk("fo", int'(fo), q[0].fo);
                    if (out_ready) void'(q.pop_front());
                end else if (cyc - q[0].acc > 3 * W) begin
                    chk("result_timeout", 0, 1);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(int'(op), int'(a), int'(b), m_fo);
                e.acc = cyc + 1;
                m_fo = e.fo;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input int o, input int ua, input int ub);
        bit got;
        @(posedge clk); #1;
        in_valid = 1'b1;
        op = 4'(o);  a = W'(ua);  b = W'(ub);
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        chk("accepted", int'(got), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit got;
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk("valid_seen", int'(got), 1);
    endtask

    task automatic pin(input string nm, input int ed, input int edh, input int efo);
        wait_valid();
        chk({nm, "_d"}, int'(d), ed);
        chk({nm, "_dh"}, int'(dh), edh);
        chk({nm, "_fo"}, int'(fo), efo);
    endtask

    int tv_op [12] = '{13, 7, 4, 5, 3, 9, 8, 9, 10, 11, 11, 1};
    int tv_a  [12] = '{5, 'h0F, 'hF0, 'h80, 'h10, 'h80, 'h81, 'hC3, 'h7F, 'h12, 0, 'h7F};
    int tv_b  [12] = '{5, 0, 'h3C, 'h01, 'h01, 3, 8, 200, 2, 'h34, 5, 0};
    int st_op [6]  = '{0, 1, 2, 3, 6, 1};
    int st_a  [6]  = '{'hFF, 0, 0, 'h10, 'h5A, 'h01};
    int st_b  [6]  = '{'h01, 0, 'h01, 'h01, 'hFF, 'h01};

    initial begin
        rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
        op = '0;  a = '0;  b = '0;
        #12;
        chk("rst_d", int'(d), 0);
        chk("rst_dh", int'(dh), 0);
        chk("rst_fo", int'(fo), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;

        issue(0, 'hFF, 'h01);  pin("add_ff_01", 'h00, 0, 'h03);
        issue(1, 'h10, 'h20);  pin("adc_carry", 'h31, 0, 'h04);
        issue(2, 'h05, 'h07);  pin("sub_borrow", 'hFE, 0, 'h09);
        issue(2, 'h80, 'h01);  pin("sub_ovf", 'h7F, 0, 'h14);
        issue(8, 'h81, 1);     pin("shl_1", 'h02, 0, 'h05);
        issue(10, 'h80, 9);    pin("asr_9", 'hFF, 0, 'h09);
        issue(9, 'h40, 0);     pin("shr_0", 'h40, 0, 'h05);
        issue(11, 'hFF, 'hFF); pin("mul_ff", 'h01, 'hFE, 'h14);

        for (int i = 0; i < 12; i++) begin
            issue(tv_op[i], tv_a[i], tv_b[i]);
            wait_valid();
        end

        // Back-to-back single-cycle stream, one op per cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            op = 4'(st_op[i]);  a = W'(st_a[i]);  b = W'(st_b[i]);
            @(negedge clk);
            chk("b2b_ready", int'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Stall in DONE, then release together with the next request.
        out_ready = 1'b0;
        issue(0, 'h12, 'h34);
        repeat (5) begin
            @(negedge clk);
            chk("hold_ready", int'(in_ready), 0);
            chk("hold_d", int'(d), 'h46);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;  op = 4'd2;  a = W'('h46);  b = W'('h06);
        @(negedge clk);
        chk("release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        pin("after_hold", 'h40, 0, 'h04);

        // Reset in the middle of a MUL.
        issue(11, 'h0F, 'h0F);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        m_fo = 0;
        #1;
        chk("abort_d", int'(d), 0);
        chk("abort_dh", int'(dh), 0);
        chk("abort_fo", int'(fo), 0);
        chk("abort_valid", int'(out_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(in_ready), 1);
        issue(0, 'h03, 'h04);  pin("post_rst_add", 'h07, 0, 'h04);

        repeat (3) @(negedge clk);
        chk("drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
